io_int_controller: RTL and testbench

- Responder end of the CPU IO/interrupt interface.
- Collects device interrupt requests and raises io_interrupt to the CPU.
- Answers the CPU's return-address, pending-interrupt and vector strobes on d_bus.
- Provides a small register file (pending, mask, vector base, status) reached through io_addr with io_write/io_push/io_read.

---
 rtl/io_int_controller_if.sv | 25 ++
 rtl/io_int_controller.sv | 161 ++++++++++++++++
 tb/tb_io_int_controller.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/io_int_controller_if.sv
// CPU-side strobe and register-select bundle for io_int_controller.
// The shared data bus stays a plain inout port on the controller.
interface io_int_controller_if;
    logic       io_read;
    logic       io_write;
    logic       io_push;
    logic [3:0] io_addr;
    logic       io_store_retaddr;
    logic       io_push_retaddr;
    logic       io_push_ints;
    logic       io_push_int_addr;
    logic       io_interrupt;

    modport master (
        output io_read, io_write, io_push, io_addr,
        output io_store_retaddr, io_push_retaddr, io_push_ints, io_push_int_addr,
        input  io_interrupt
    );

    modport slave (
        input  io_read, io_write, io_push, io_addr,
        input  io_store_retaddr, io_push_retaddr, io_push_ints, io_push_int_addr,
        output io_interrupt
    );
endinterface

// File: rtl/io_int_controller.sv
// Interrupt collector and IO register responder for the CPU IO/interrupt interface.
// Define IOC_LEVEL_IRQ_EN to make pending bits follow the synchronised irq_in level.
module io_int_controller #(
    parameter int unsigned NUM_IRQ    = 8,
    parameter int unsigned VEC_STRIDE = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_in,
    io_int_controller_if.slave bus,
    inout  wire  [15:0]        d_bus
);
    typedef enum logic {IDLE, SERVICE} state_t;

    state_t             state;
    logic [NUM_IRQ-1:0] sync1, sync2, pending, mask, active, sel_hot;
    logic [15:0]        vecbase, retaddr, pend16, mask16, status, reg_rd, vec_addr, drv_val;
    logic [3:0]         isr_idx, sel_idx;
    logic               isr_valid, isr_err, any_active, sel_found, drv_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= irq_in;
            sync2 <= sync1;
        end
    end

    assign active     = pending & mask;
    assign any_active = |active;

    // Lowest-numbered enabled pending source wins.
    always_comb begin
        sel_idx   = '0;
        sel_hot   = '0;
        sel_found = 1'b0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (active[i] && !sel_found) begin
                sel_idx    = 4'(i);
                sel_hot[i] = 1'b1;
                sel_found  = 1'b1;
            end
        end
    end

`ifdef IOC_LEVEL_IRQ_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending <= '0;
        else        pending <= sync2;
    end
`else
    logic [NUM_IRQ-1:0] sync3, pend_set, pend_clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync3 <= '0;
        else        sync3 <= sync2;
    end

    assign pend_set = sync2 & ~sync3;

    always_comb begin
        pend_clr = '0;
        if (bus.io_write && bus.io_addr == 4'd0) pend_clr = d_bus[NUM_IRQ-1:0];
        if (bus.io_read && bus.io_addr == 4'd0)  pend_clr = pending;
        if (state == IDLE && bus.io_store_retaddr) pend_clr = pend_clr | sel_hot;
    end

    // A new edge in the same cycle as any clear keeps the bit set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending <= '0;
        else        pending <= (pending & ~pend_clr) | pend_set;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask    <= '0;
            vecbase <= '0;
        end else if (bus.io_write) begin
            if (bus.io_addr == 4'd1) mask    <= d_bus[NUM_IRQ-1:0];
            if (bus.io_addr == 4'd2) vecbase <= d_bus;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            retaddr   <= '0;
            isr_idx   <= '0;
            isr_valid <= 1'b0;
            isr_err   <= 1'b0;
        end else begin
            if (bus.io_write && bus.io_addr == 4'd3) isr_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.io_store_retaddr) begin
                        retaddr   <= d_bus;
                        isr_idx   <= sel_idx;
                        isr_valid <= any_active;
                        state     <= SERVICE;
                    end
                end
                SERVICE: begin
                    if (bus.io_store_retaddr) isr_err <= 1'b1;
                    if (bus.io_push_retaddr) begin
                        isr_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.io_interrupt = (state == IDLE) && any_active;

    always_comb begin
        pend16                = '0;
        mask16                = '0;
        pend16[NUM_IRQ-1:0]   = pending;
        mask16[NUM_IRQ-1:0]   = mask;
    end

    assign status   = {isr_valid, isr_err, 10'd0, isr_idx};
    assign vec_addr = vecbase + 16'(isr_idx) * 16'(VEC_STRIDE);

    always_comb begin
        case (bus.io_addr)
            4'd0:    reg_rd = pend16;
            4'd1:    reg_rd = mask16;
            4'd2:    reg_rd = vecbase;
            4'd3:    reg_rd = status;
            default: reg_rd = '0;
        endcase
    end

    // The CPU owns the bus during writes and return-address stores.
    always_comb begin
        drv_en  = 1'b0;
        drv_val = '0;
        if (!(bus.io_write || bus.io_store_retaddr)) begin
            if (bus.io_push_retaddr) begin
                drv_en  = 1'b1;
                drv_val = retaddr;
            end else if (bus.io_push_int_addr) begin
                drv_en  = 1'b1;
                drv_val = vec_addr;
            end else if (bus.io_push_ints) begin
                drv_en  = 1'b1;
                drv_val = pend16 & mask16;
            end else if (bus.io_push) begin
                drv_en  = 1'b1;
                drv_val = reg_rd;
            end
        end
    end

    assign d_bus = drv_en ? drv_val : 'z;
endmodule

// File: tb/tb_io_int_controller.sv
// Directed bench for io_int_controller: register table plus interrupt/service sequences.
// d_bus is a pulled-up net, so an undriven bus reads 0xFFFF.
module tb_io_int_controller;
    localparam int unsigned NUM_IRQ = 8;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NUM_IRQ-1:0] irq_in;
    tri1  [15:0]        d_bus;
    logic               tb_drive;
    logic [15:0]        tb_data;
    int                 n_cmp = 0;
    int                 n_bad = 0;

    io_int_controller_if bus_if ();

    assign d_bus = tb_drive ? tb_data : 16'bz;

    io_int_controller #(.NUM_IRQ(NUM_IRQ), .VEC_STRIDE(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .irq_in(irq_in),
        .bus   (bus_if),
        .d_bus (d_bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [3:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input logic exp);
        check(name, {15'd0, bus_if.io_interrupt}, {15'd0, exp});
    endtask

    task automatic quiet();
        bus_if.io_read          = 1'b0;
        bus_if.io_write         = 1'b0;
        bus_if.io_push          = 1'b0;
        bus_if.io_store_retaddr = 1'b0;
        bus_if.io_push_retaddr  = 1'b0;
        bus_if.io_push_ints     = 1'b0;
        bus_if.io_push_int_addr = 1'b0;
        tb_drive                = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_reg(input logic [3:0] a, input logic [15:0] exp, input string name);
        @(negedge clk);
        bus_if.io_addr = a;
        bus_if.io_push = 1'b1;
        #1;
        check(name, d_bus, exp);
        bus_if.io_push = 1'b0;
    endtask

    task automatic wr_reg(input logic [3:0] a, input logic [15:0] d);
        bus_if.io_addr  = a;
        tb_data         = d;
        tb_drive        = 1'b1;
        bus_if.io_write = 1'b1;
        tick();
        quiet();
    endtask

    task automatic store(input logic [15:0] d);
        tb_data                 = d;
        tb_drive                = 1'b1;
        bus_if.io_store_retaddr = 1'b1;
        tick();
        quiet();
    endtask

    task automatic push_vec(input logic [15:0] exp, input string name);
        @(negedge clk);
        bus_if.io_push_int_addr = 1'b1;
        #1;
        check(name, d_bus, exp);
        quiet();
    endtask

    task automatic retire(input logic [15:0] exp, input string name);
        @(negedge clk);
        bus_if.io_push_retaddr = 1'b1;
        #1;
        check(name, d_bus, exp);
        tick();
        quiet();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b1, 4'd1,  16'hFFFF, 16'h00FF};
        vecs[1] = '{1'b1, 4'd2,  16'hBEEF, 16'hBEEF};
        vecs[2] = '{1'b1, 4'd5,  16'h1234, 16'h0000};
        vecs[3] = '{1'b1, 4'd15, 16'hFFFF, 16'h0000};
        vecs[4] = '{1'b1, 4'd3,  16'hFFFF, 16'h0000};
        vecs[5] = '{1'b1, 4'd0,  16'hFFFF, 16'h0000};
        vecs[6] = '{1'b0, 4'd1,  16'h0000, 16'h00FF};
        vecs[7] = '{1'b0, 4'd2,  16'h0000, 16'hBEEF};
        vecs[8] = '{1'b1, 4'd1,  16'h0005, 16'h0005};
        vecs[9] = '{1'b1, 4'd2,  16'h0100, 16'h0100};

        rst_n          = 1'b0;
        irq_in         = '0;
        tb_data        = '0;
        bus_if.io_addr = '0;
        quiet();
        #1;
        check_int("reset_int", 1'b0);
        check("reset_bus_z", d_bus, 16'hFFFF);
        rd_reg(4'd3, 16'h0000, "reset_status");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int unsigned i = 0; i < 10; i++) begin
            if (vecs[i].wr) wr_reg(vecs[i].addr, vecs[i].wdata);
            rd_reg(vecs[i].addr, vecs[i].exp, $sformatf("tbl%0d_addr%0d", i, vecs[i].addr));
        end

        // Pushes are suppressed while the CPU writes.
        @(negedge clk);
        bus_if.io_addr         = 4'd4;
        bus_if.io_write        = 1'b1;
        bus_if.io_push         = 1'b1;
        bus_if.io_push_retaddr = 1'b1;
        #1;
        check("write_blocks_push", d_bus, 16'hFFFF);
        tick();
        quiet();

        // Two-source pulse: interrupt appears exactly three edges later.
        tick();
        irq_in = 8'h05;
        tick();
        tick();
        check_int("latency_2clk", 1'b0);
        tick();
        check_int("latency_3clk", 1'b1);
        irq_in = '0;
        rd_reg(4'd0, 16'h0005, "pending_after_pulse");

        store(16'h1234);
        rd_reg(4'd3, 16'h8000, "status_idx0");
        rd_reg(4'd0, 16'h0004, "pending_after_take0");
        check_int("no_nesting", 1'b0);
        push_vec(16'h0100, "vec_idx0");
        retire(16'h1234, "retaddr_1234");
        check_int("reassert_bit2", 1'b1);
        rd_reg(4'd3, 16'h0000, "status_after_ret");

        store(16'h2222);
        rd_reg(4'd3, 16'h8002, "status_idx2");
        rd_reg(4'd0, 16'h0000, "pending_after_take2");
        push_vec(16'h0104, "vec_idx2");
        @(negedge clk);
        bus_if.io_push_ints = 1'b1;
        #1;
        check("push_ints_empty", d_bus, 16'h0000);
        quiet();

        // Store while already in service is flagged and leaves retaddr alone.
        store(16'h5555);
        rd_reg(4'd3, 16'hC002, "status_err_set");
        @(negedge clk);
        bus_if.io_addr         = 4'd3;
        bus_if.io_push         = 1'b1;
        bus_if.io_push_retaddr = 1'b1;
        #1;
        check("retaddr_priority", d_bus, 16'h2222);
        tick();
        quiet();
        rd_reg(4'd3, 16'h4002, "status_err_idle");
        wr_reg(4'd3, 16'h0000);
        rd_reg(4'd3, 16'h0002, "status_err_clr");

        irq_in[3] = 1'b1;
        tick();
        tick();
        tick();
        rd_reg(4'd0, 16'h0008, "pending_masked3");
        check_int("masked_no_int", 1'b0);
        wr_reg(4'd0, 16'h0008);
        rd_reg(4'd0, 16'h0000, "w1c_clear3");
        irq_in = '0;
        tick();
        tick();
        tick();

        irq_in[0] = 1'b1;
        tick();
        tick();
        tick();
        rd_reg(4'd0, 16'h0001, "pending_bit0");
        check_int("int_bit0", 1'b1);
        bus_if.io_addr = 4'd1;
        bus_if.io_read = 1'b1;
        tick();
        quiet();
        rd_reg(4'd0, 16'h0001, "read_addr1_noeffect");
        bus_if.io_addr = 4'd0;
        bus_if.io_read = 1'b1;
        tick();
        quiet();
        rd_reg(4'd0, 16'h0000, "read_addr0_clears");
        check_int("int_after_read", 1'b0);

        // W1C lands on the same edge that records a new rising edge.
        tick();
        irq_in[1] = 1'b1;
        tick();
        tick();
        wr_reg(4'd0, 16'h0002);
        rd_reg(4'd0, 16'h0002, "set_beats_w1c");

        store(16'h7777);
        rd_reg(4'd3, 16'h0000, "trap_status");
        store(16'h8888);
        rd_reg(4'd3, 16'h4000, "trap_in_service");
        rd_reg(4'd0, 16'h0002, "trap_keeps_pending");
        retire(16'h7777, "trap_retaddr");
        wr_reg(4'd3, 16'h0000);

        wr_reg(4'd2, 16'hFFFF);
        wr_reg(4'd1, 16'h0002);
        check_int("int_bit1", 1'b1);
        store(16'h3333);
        rd_reg(4'd3, 16'h8001, "status_idx1");
        push_vec(16'h0001, "vec_wrap");

        // Asynchronous reset while in service, checked before the next edge.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_int("rst_mid_int", 1'b0);
        bus_if.io_addr = 4'd3;
        bus_if.io_push = 1'b1;
        #1;
        check("rst_mid_status", d_bus, 16'h0000);
        bus_if.io_addr = 4'd1;
        #1;
        check("rst_mid_mask", d_bus, 16'h0000);
        quiet();
        #1;
        check("rst_mid_bus_z", d_bus, 16'hFFFF);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        rd_reg(4'd0, 16'h0000, "post_rst_pending");
        check_int("post_rst_int", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
